// File: rtl/mem_burst_arb_pkg.sv
// Shared types for the mem_burst_arb block: FSM states, operation kind, stats width.
package mem_burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_BUSY,
    WR_BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } arb_op_t;

  localparam int unsigned STAT_BITS = 32;

endpackage

// File: rtl/mem_burst_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]                            req,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]   ptr,
  output logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]   grant,
  output logic                                         valid
);

  localparam int unsigned PW = $clog2(NUM_CH > 1 ? NUM_CH : 2);

  int unsigned idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(ptr) + k) % NUM_CH;
      if (!valid && req[idx]) begin
        grant = PW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_burst_arb.sv
// N-channel round-robin burst arbiter in front of a single DDR4 burst port.
// Optional statistics counters are built when MEM_BURST_ARB_STATS_EN is defined.
module mem_burst_arb
  import mem_burst_arb_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned MEM_DATA_BITS = 256,
  parameter int unsigned ADDR_BITS     = 28,
  parameter int unsigned LEN_BITS      = 10
) (
  input  logic                              mem_clk,
  input  logic                              rst,
  input  logic                              init_calib_complete,
  input  logic [NUM_CH-1:0]                 ch_rd_req,
  input  logic [NUM_CH*LEN_BITS-1:0]        ch_rd_len,
  input  logic [NUM_CH*ADDR_BITS-1:0]       ch_rd_addr,
  output logic [MEM_DATA_BITS-1:0]          ch_rd_data,
  output logic [NUM_CH-1:0]                 ch_rd_data_valid,
  output logic [NUM_CH-1:0]                 ch_rd_finish,
  input  logic [NUM_CH-1:0]                 ch_wr_req,
  input  logic [NUM_CH*LEN_BITS-1:0]        ch_wr_len,
  input  logic [NUM_CH*ADDR_BITS-1:0]       ch_wr_addr,
  input  logic [NUM_CH*MEM_DATA_BITS-1:0]   ch_wr_data,
  output logic [NUM_CH-1:0]                 ch_wr_data_req,
  output logic [NUM_CH-1:0]                 ch_wr_finish,
  output logic                              rd_burst_req,
  output logic                              wr_burst_req,
  output logic [LEN_BITS-1:0]               rd_burst_len,
  output logic [LEN_BITS-1:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]              rd_burst_addr,
  output logic [ADDR_BITS-1:0]              wr_burst_addr,
  input  logic                              rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0]          rd_burst_data,
  input  logic                              rd_burst_finish,
  input  logic                              wr_burst_finish,
  input  logic                              wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0]          wr_burst_data
`ifdef MEM_BURST_ARB_STATS_EN
  ,
  output logic [NUM_CH*STAT_BITS-1:0]       stat_grant_cnt,
  output logic [STAT_BITS-1:0]              stat_busy_cnt
`endif
);

  localparam int unsigned PW = $clog2(NUM_CH > 1 ? NUM_CH : 2);

  arb_state_t              state;
  arb_op_t                 op;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           grant;
  logic [PW-1:0]           win;
  logic                    win_valid;
  logic                    grant_fire;
  logic                    zero_len;

  logic [LEN_BITS-1:0]      rd_len_a  [NUM_CH];
  logic [LEN_BITS-1:0]      wr_len_a  [NUM_CH];
  logic [ADDR_BITS-1:0]     rd_addr_a [NUM_CH];
  logic [ADDR_BITS-1:0]     wr_addr_a [NUM_CH];
  logic [MEM_DATA_BITS-1:0] wr_data_a [NUM_CH];

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_len_a[i]  = ch_rd_len[i*LEN_BITS +: LEN_BITS];
      wr_len_a[i]  = ch_wr_len[i*LEN_BITS +: LEN_BITS];
      rd_addr_a[i] = ch_rd_addr[i*ADDR_BITS +: ADDR_BITS];
      wr_addr_a[i] = ch_wr_addr[i*ADDR_BITS +: ADDR_BITS];
      wr_data_a[i] = ch_wr_data[i*MEM_DATA_BITS +: MEM_DATA_BITS];
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .req   (ch_rd_req | ch_wr_req),
    .ptr   (ptr),
    .grant (win),
    .valid (win_valid)
  );

  assign grant_fire = (state == IDLE) && init_calib_complete && win_valid;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return (g == PW'(NUM_CH - 1)) ? '0 : g + 1'b1;
  endfunction

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state         <= IDLE;
      op            <= OP_RD;
      ptr           <= '0;
      grant         <= '0;
      zero_len      <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      wr_burst_len  <= '0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            grant    <= win;
            zero_len <= 1'b0;
            if (ch_rd_req[win]) begin
              op            <= OP_RD;
              rd_burst_len  <= rd_len_a[win];
              rd_burst_addr <= rd_addr_a[win];
              if (rd_len_a[win] != '0) begin
                rd_burst_req <= 1'b1;
                state        <= RD_BUSY;
              end else begin
                zero_len <= 1'b1;
                ptr      <= ptr_after(win);
                state    <= DONE;
              end
            end else begin
              op            <= OP_WR;
              wr_burst_len  <= wr_len_a[win];
              wr_burst_addr <= wr_addr_a[win];
              if (wr_len_a[win] != '0) begin
                wr_burst_req <= 1'b1;
                state        <= WR_BUSY;
              end else begin
                zero_len <= 1'b1;
                ptr      <= ptr_after(win);
                state    <= DONE;
              end
            end
          end
        end
        RD_BUSY: begin
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            ptr          <= ptr_after(grant);
            state        <= DONE;
          end
        end
        WR_BUSY: begin
          if (wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            ptr          <= ptr_after(grant);
            state        <= DONE;
          end
        end
        DONE: begin
          zero_len <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-length grants report completion from DONE, one cycle after the decision.
  always_comb begin
    ch_rd_data_valid = '0;
    ch_wr_data_req   = '0;
    ch_rd_finish     = '0;
    ch_wr_finish     = '0;
    if (state == RD_BUSY) begin
      ch_rd_data_valid[grant] = rd_burst_data_valid;
      ch_rd_finish[grant]     = rd_burst_finish;
    end
    if (state == WR_BUSY) begin
      ch_wr_data_req[grant] = wr_burst_data_req;
      ch_wr_finish[grant]   = wr_burst_finish;
    end
    if (state == DONE && zero_len) begin
      if (op == OP_RD) ch_rd_finish[grant] = 1'b1;
      else             ch_wr_finish[grant] = 1'b1;
    end
  end

  assign ch_rd_data    = rd_burst_data;
  assign wr_burst_data = wr_data_a[grant];

`ifdef MEM_BURST_ARB_STATS_EN
  logic [STAT_BITS-1:0] grant_cnt [NUM_CH];

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) grant_cnt[i] <= '0;
      stat_busy_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (grant_fire && 32'(win) == i) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if (state == RD_BUSY || state == WR_BUSY) stat_busy_cnt <= stat_busy_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      stat_grant_cnt[i*STAT_BITS +: STAT_BITS] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_arb.sv
// Directed, table-driven bench for mem_burst_arb (4 channels) plus a contention sequence.
module tb_mem_burst_arb;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 28;
  localparam int unsigned LW  = 10;

  logic                mem_clk = 1'b0;
  logic                rst;
  logic                init_calib_complete;
  logic [NCH-1:0]      ch_rd_req;
  logic [NCH*LW-1:0]   ch_rd_len;
  logic [NCH*AW-1:0]   ch_rd_addr;
  logic [DW-1:0]       ch_rd_data;
  logic [NCH-1:0]      ch_rd_data_valid;
  logic [NCH-1:0]      ch_rd_finish;
  logic [NCH-1:0]      ch_wr_req;
  logic [NCH*LW-1:0]   ch_wr_len;
  logic [NCH*AW-1:0]   ch_wr_addr;
  logic [NCH*DW-1:0]   ch_wr_data;
  logic [NCH-1:0]      ch_wr_data_req;
  logic [NCH-1:0]      ch_wr_finish;
  logic                rd_burst_req, wr_burst_req;
  logic [LW-1:0]       rd_burst_len, wr_burst_len;
  logic [AW-1:0]       rd_burst_addr, wr_burst_addr;
  logic                rd_burst_data_valid;
  logic [DW-1:0]       rd_burst_data;
  logic                rd_burst_finish, wr_burst_finish;
  logic                wr_burst_data_req;
  logic [DW-1:0]       wr_burst_data;
`ifdef MEM_BURST_ARB_STATS_EN
  logic [NCH*32-1:0]   stat_grant_cnt;
  logic [31:0]         stat_busy_cnt;
`endif

  always #5 mem_clk = ~mem_clk;

  mem_burst_arb #(
    .NUM_CH        (NCH),
    .MEM_DATA_BITS (DW),
    .ADDR_BITS     (AW),
    .LEN_BITS      (LW)
  ) dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .ch_rd_req           (ch_rd_req),
    .ch_rd_len           (ch_rd_len),
    .ch_rd_addr          (ch_rd_addr),
    .ch_rd_data          (ch_rd_data),
    .ch_rd_data_valid    (ch_rd_data_valid),
    .ch_rd_finish        (ch_rd_finish),
    .ch_wr_req           (ch_wr_req),
    .ch_wr_len           (ch_wr_len),
    .ch_wr_addr          (ch_wr_addr),
    .ch_wr_data          (ch_wr_data),
    .ch_wr_data_req      (ch_wr_data_req),
    .ch_wr_finish        (ch_wr_finish),
    .rd_burst_req        (rd_burst_req),
    .wr_burst_req        (wr_burst_req),
    .rd_burst_len        (rd_burst_len),
    .wr_burst_len        (wr_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .wr_burst_addr       (wr_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_finish     (wr_burst_finish),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data)
`ifdef MEM_BURST_ARB_STATS_EN
    ,
    .stat_grant_cnt      (stat_grant_cnt),
    .stat_busy_cnt       (stat_busy_cnt)
`endif
  );

  typedef struct {
    logic        rst, cal;
    logic [3:0]  rdq, wrq;
    logic        dv, rfin, wdr, wfin;
    logic        rbq, wbq;
    logic [3:0]  crdv, crf, cwdr, cwf;
    logic        chk;
    logic [LW-1:0] elen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d] got=%h exp=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic [3:0] rq, input logic [3:0] wq,
                     input logic dv, input logic rf, input logic wd, input logic wf,
                     input logic eb_r, input logic eb_w,
                     input logic [3:0] e_rdv, input logic [3:0] e_rf,
                     input logic [3:0] e_wdr, input logic [3:0] e_wf);
    vec_t v;
    v.rst = r; v.cal = c; v.rdq = rq; v.wrq = wq;
    v.dv = dv; v.rfin = rf; v.wdr = wd; v.wfin = wf;
    v.rbq = eb_r; v.wbq = eb_w;
    v.crdv = e_rdv; v.crf = e_rf; v.cwdr = e_wdr; v.cwf = e_wf;
    v.chk = 1'b0; v.elen = '0; v.eaddr = '0; v.ewd = '0;
    vq.push_back(v);
  endtask

  // Also check the downstream len/addr (and write data mux when a write is active) on the last vector.
  task automatic add_la(input logic [LW-1:0] l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    vq[vq.size()-1].chk   = 1'b1;
    vq[vq.size()-1].elen  = l;
    vq[vq.size()-1].eaddr = a;
    vq[vq.size()-1].ewd   = d;
  endtask

  initial begin
    int cnt, nfin, last;
    bit done_cont;

    for (int i = 0; i < int'(NCH); i++) begin
      ch_rd_len[i*LW +: LW]  = (i == 2) ? LW'(0) : LW'(4);
      ch_rd_addr[i*AW +: AW] = AW'(32'h100 * i);
      ch_wr_len[i*LW +: LW]  = LW'(2);
      ch_wr_addr[i*AW +: AW] = AW'(32'h800 + i);
      ch_wr_data[i*DW +: DW] = 32'hDA7A_0000 + 32'(i);
    end
    rst = 1'b1; init_calib_complete = 1'b0;
    ch_rd_req = '0; ch_wr_req = '0;
    rd_burst_data_valid = 1'b0; rd_burst_data = 32'hCAFE_F00D;
    rd_burst_finish = 1'b0; wr_burst_finish = 1'b0; wr_burst_data_req = 1'b0;
    repeat (3) @(negedge mem_clk);

    //   rst cal rdq    wrq    dv rf wd wf  rbq wbq crdv   crf    cwdr   cwf
    add(1, 1, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 0 reset
    add(0, 1, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 1 grant ch1
    add(0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000); // 2
    add_la(LW'(4), AW'(32'h100), 32'hDA7A_0000 + 32'd1);
    add(0, 1, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 3
    add(0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000); // 4
    add(0, 1, 4'b0010, 4'b0000, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000); // 5
    add(0, 1, 4'b0010, 4'b0000, 1, 1, 0, 0, 1, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000); // 6 finish
    add(0, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 7 DONE, stray fin
    add(0, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 8 IDLE, stray fin
    add(0, 1, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 9 ch2 len=0
    add(0, 1, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000); // 10 zero-len finish
    add(0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 11
    add(0, 1, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 12 ch0 rd+wr
    add(0, 1, 4'b0001, 4'b0001, 0, 1, 0, 0, 1, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000); // 13 read first
    add(0, 1, 4'b0000, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 14 DONE
    add(0, 1, 4'b0000, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 15 grant wr ch0
    add(0, 1, 4'b0000, 4'b0001, 0, 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000); // 16
    add(0, 1, 4'b0000, 4'b0001, 0, 0, 1, 1, 0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001); // 17 wr finish
    add(0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 18
    add(0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 19 calib low
    add(0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 20
    add(0, 1, 4'b0000, 4'b0100, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 21 grant wr ch2
    add(0, 0, 4'b0000, 4'b0100, 0, 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 4'b0000); // 22 calib drops
    add_la(LW'(2), AW'(32'h802), 32'hDA7A_0002);
    add(0, 0, 4'b0000, 4'b0100, 0, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100); // 23 completes
    add(0, 0, 4'b0000, 4'b0100, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 24 DONE
    add(0, 0, 4'b0000, 4'b0100, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 25 no grant
    add(0, 1, 4'b1000, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 26 grant rd ch3
    add(0, 1, 4'b1000, 4'b0001, 1, 0, 0, 0, 1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000); // 27
    add(1, 1, 4'b1000, 4'b0001, 1, 0, 0, 0, 1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000); // 28 rst mid-burst
    add(0, 1, 4'b1000, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 29 req dropped
    add(0, 1, 4'b1000, 4'b0001, 0, 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000); // 30 ch0 after reset
    add_la(LW'(2), AW'(32'h800), 32'hDA7A_0000);
    add(0, 1, 4'b1000, 4'b0000, 0, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001); // 31
    add(0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 32
    add(0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // 33

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge mem_clk);
      rst = vq[i].rst; init_calib_complete = vq[i].cal;
      ch_rd_req = vq[i].rdq; ch_wr_req = vq[i].wrq;
      rd_burst_data_valid = vq[i].dv; rd_burst_finish = vq[i].rfin;
      wr_burst_data_req = vq[i].wdr; wr_burst_finish = vq[i].wfin;
      #1;
      check("rd_burst_req",     i, 32'(rd_burst_req),     32'(vq[i].rbq));
      check("wr_burst_req",     i, 32'(wr_burst_req),     32'(vq[i].wbq));
      check("ch_rd_data_valid", i, 32'(ch_rd_data_valid), 32'(vq[i].crdv));
      check("ch_rd_finish",     i, 32'(ch_rd_finish),     32'(vq[i].crf));
      check("ch_wr_data_req",   i, 32'(ch_wr_data_req),   32'(vq[i].cwdr));
      check("ch_wr_finish",     i, 32'(ch_wr_finish),     32'(vq[i].cwf));
      if (vq[i].chk) begin
        if (vq[i].rbq) begin
          check("rd_burst_len",  i, 32'(rd_burst_len),  32'(vq[i].elen));
          check("rd_burst_addr", i, 32'(rd_burst_addr), 32'(vq[i].eaddr));
        end else begin
          check("wr_burst_len",  i, 32'(wr_burst_len),  32'(vq[i].elen));
          check("wr_burst_addr", i, 32'(wr_burst_addr), 32'(vq[i].eaddr));
          check("wr_burst_data", i, wr_burst_data,      vq[i].ewd);
        end
      end
    end
    check("ch_rd_data", 0, ch_rd_data, 32'hCAFE_F00D);

    // Contention: all four channels write continuously; downstream finishes on the 3rd busy cycle.
    @(negedge mem_clk);
    rst = 1'b1; ch_rd_req = '0; ch_wr_req = '0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0; wr_burst_data_req = 1'b0;
    @(negedge mem_clk);
    rst = 1'b0; init_calib_complete = 1'b1; ch_wr_req = 4'b1111;
    cnt = 0; nfin = 0; last = 0; done_cont = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_cont; cyc++) begin
      if (wr_burst_req) cnt++;
      wr_burst_finish   = wr_burst_req && (cnt == 3);
      wr_burst_data_req = wr_burst_req;
      if (wr_burst_finish) cnt = 0;
      #1;
      if (ch_wr_finish != '0) begin
        check("cont_order", nfin, 32'(ch_wr_finish), 32'(1) << (nfin % 4));
        if (nfin > 0) check("cont_gap", nfin, 32'(cyc - last), 32'd5);
        last = cyc;
        nfin++;
        if (nfin == 5) done_cont = 1'b1;
      end
      @(negedge mem_clk);
    end
    check("cont_finishes", 0, 32'(nfin), 32'd5);
`ifdef MEM_BURST_ARB_STATS_EN
    check("stat_grant0", 0, stat_grant_cnt[0  +: 32], 32'd2);
    check("stat_grant1", 1, stat_grant_cnt[32 +: 32], 32'd1);
    check("stat_grant3", 3, stat_grant_cnt[96 +: 32], 32'd1);
`endif
    ch_wr_req = '0; wr_burst_finish = 1'b0; wr_burst_data_req = 1'b0;
    repeat (2) @(negedge mem_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
